// File: rtl/spi_pkg.sv
// Shared definitions for the streaming SPI slave: mode constants, FSM encoding and
// the helper that picks the sampling edge for a given CPOL/CPHA pair.
`timescale 1ns/1ps
package spi_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StShift = 2'd2
   } spi_state_e;

   // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, followed by a stability
// stage that only follows the chain once every stage agrees (rejects short glitches).
`timescale 1ns/1ps
module spi_sync #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic              q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= {STAGES{RESET_VAL}};
         q_q     <= RESET_VAL;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
         // A pulse narrower than STAGES cycles never fills the whole chain.
         if (chain_q == {STAGES{chain_q[0]}}) begin
            q_q <= chain_q[0];
         end
      end
   end

   assign q = q_q;

endmodule

// File: rtl/spi_slave_stream.sv
// Full-duplex SPI slave with a valid/ready tx holding register, multi-word bursts
// under one chip select and any CPOL/CPHA mode. All SPI inputs are synchronised to clk.
`timescale 1ns/1ps
module spi_slave_stream
   import spi_pkg::*;
#(
   parameter logic              CPOL         = 1'b0,
   parameter logic              CPHA         = 1'b0,
   parameter int unsigned       WIDTH        = 16,
   parameter int unsigned       SYNC_STAGES  = 2,
   parameter logic [WIDTH-1:0]  DEFAULT_WORD = WIDTH'(16'h0AAA)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             mosi,
   output logic             miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_abort,
   output logic             tx_underrun,
   output logic             busy
);

   localparam int unsigned   CNT_W       = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   // Synchronised inputs and edge detection
   logic sclk_s, cs_s, mosi_s;
   logic sclk_prev_q;
   logic sclk_rise, sclk_fall, sample_edge, drive_edge;

   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
      .clk (clk),
      .rst (rst),
      .d   (sclk),
      .q   (sclk_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk (clk),
      .rst (rst),
      .d   (cs),
      .q   (cs_s)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk (clk),
      .rst (rst),
      .d   (mosi),
      .q   (mosi_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_prev_q <= CPOL;
      end else begin
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign drive_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

   // FSM and datapath state
   spi_state_e       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [WIDTH-1:0] hold_q;
   logic             hold_full_q;
   logic [WIDTH-1:0] shift_q;
   logic             miso_q;
   logic [WIDTH-2:0] rx_shift_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;
   logic             rx_abort_q;
   logic             default_pend_q;

   logic             active;
   logic             word_done;
   logic             tx_hs;
   logic             load_now;
   logic             have_word;
   logic [WIDTH-1:0] load_word;
   logic [WIDTH-1:0] rx_word;
   logic             miso_en;

   assign active    = (state_q == StShift) && !cs_s;
   assign word_done = active && sample_edge && (bit_cnt_q == LAST_BIT);
   assign tx_hs     = tx_valid && !hold_full_q;
   assign load_now  = (state_q == StLoad) || word_done;
   assign have_word = hold_full_q || tx_valid;
   // A handshake in the load cycle bypasses the holding register.
   assign load_word = hold_full_q ? hold_q : (tx_valid ? tx_data : DEFAULT_WORD);
   assign rx_word   = {rx_shift_q, mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!cs_s) state_d = StLoad;
         StLoad:  state_d = StShift;
         StShift: if (cs_s) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A DEFAULT_WORD reloaded at a word boundary only counts as an underrun once the
   // master actually clocks its first bit; a burst that ends cleanly raises nothing.
   always_comb begin
      miso_en     = 1'b0;
      tx_underrun = 1'b0;
      unique case (state_q)
         StIdle: begin
            miso_en = 1'b0;
         end
         StLoad: begin
            miso_en     = 1'b1;
            tx_underrun = !have_word;
         end
         StShift: begin
            miso_en     = 1'b1;
            tx_underrun = active && sample_edge && (bit_cnt_q == '0) && default_pend_q;
         end
         default: begin
            miso_en = 1'b0;
         end
      endcase
   end

   // Holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else if (load_now) begin
         hold_full_q <= 1'b0;
      end else if (tx_hs) begin
         hold_q      <= tx_data;
         hold_full_q <= 1'b1;
      end
   end

   // Shift registers, bit counter and receive path
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         miso_q         <= 1'b0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rx_abort_q     <= 1'b0;
         default_pend_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_abort_q <= (state_q == StShift) && cs_s && (bit_cnt_q != '0);

         if (state_q == StLoad) begin
            bit_cnt_q <= '0;
         end else if (active) begin
            if (sample_edge) begin
               rx_shift_q <= rx_word[WIDTH-2:0];
               if (bit_cnt_q == '0) begin
                  default_pend_q <= 1'b0;
               end
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_q  <= '0;
                  rx_data_q  <= rx_word;
                  rx_valid_q <= 1'b1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               end
            end else if (drive_edge && (CPHA || (bit_cnt_q != '0))) begin
               // CPHA=0 holds the MSB until the first sample; CPHA=1 advances every drive edge.
               miso_q  <= shift_q[WIDTH-1];
               shift_q <= shift_q << 1;
            end
         end

         if (load_now) begin
            miso_q         <= load_word[WIDTH-1];
            shift_q        <= CPHA ? load_word : {load_word[WIDTH-2:0], 1'b0};
            default_pend_q <= word_done && !have_word;
         end
      end
   end

   assign miso     = miso_en ? miso_q : 1'bz;
   assign tx_ready = !hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_abort = rx_abort_q;
   assign busy     = !cs_s;

endmodule
